vga_grid_avl_interface: RTL and testbench
=========================================

VGA_GRID_AVL_INTERFACE -- requirements
Module: vga_grid_avl_interface

Interface
REQ-001 SHALL have parameter COLS, default 10, meaning grid columns (cells).
REQ-002 SHALL have parameter ROWS, default 20, meaning grid rows (cells).
REQ-003 SHALL have parameter CELL_PX, default 16, meaning cell edge in pixels (power of two).
REQ-004 SHALL have parameter CODE_W, default 3, meaning cell colour-code width; palette depth 2^CODE_W.
REQ-005 SHALL have parameter COLOR_W, default 4, meaning bits per RGB channel.
REQ-006 SHALL have parameters X0 default 240 and Y0 default 80, meaning grid top-left pixel.
REQ-007 SHALL have parameter CLK_DIV, default 2, meaning CLK cycles per pixel.
REQ-008 CLK  input  1  single clock; all state on its rising edge.
REQ-009 RESET  input  1  asynchronous, active-high reset.
REQ-010 AVL_CS, AVL_READ, AVL_WRITE  input  1 each  Avalon-MM slave strobes.
REQ-011 AVL_BYTE_EN  input  4  byte enables.
REQ-012 AVL_ADDR  input  A = clog2(COLS*ROWS + 2^CODE_W + 1)  word address.
REQ-013 AVL_WRITEDATA  input  32 / AVL_READDATA  output  32  data buses.
REQ-014 red, green, blue  output  COLOR_W each  pixel colour.
REQ-015 hs, vs  output  1 each  active-low syncs.

Function
REQ-016 Map: 0..N-1 cell RAM (N=COLS*ROWS, row-major, code in bits CODE_W-1:0); N..N+2^CODE_W-1 palette ({r,g,b} in bits 3*COLOR_W-1:0); N+2^CODE_W control (bit0 EN, bits CODE_W:1 border code).
REQ-017 Write on AVL_CS & AVL_WRITE; byte lane k written only if AVL_BYTE_EN[k]; addresses beyond control ignored.
REQ-018 Read on AVL_CS & AVL_READ & !AVL_WRITE; AVL_READDATA valid next cycle, zero-extended; out-of-range returns 0; held until next read.
REQ-019 Simultaneous read+write: write performed, AVL_READDATA unchanged.
REQ-020 Pixel enable pe pulses one CLK in every CLK_DIV, divider counting from reset release.
REQ-021 Horizontal counter hc 0..799 on pe, wraps to 0; vertical vc 0..524 increments when hc wraps, wraps to 0.
REQ-022 Timing: visible hc<640, vc<480; hs low for hc 656..751; vs low for vc 490..491.
REQ-023 Grid region: X0<=hc<X0+COLS*CELL_PX and Y0<=vc<Y0+ROWS*CELL_PX; cell = ((vc-Y0)/CELL_PX)*COLS + (hc-X0)/CELL_PX, shifts only.
REQ-024 Border: one-pixel frame just outside grid region drawn with palette[border code].
REQ-025 Pipeline: stage 1 registers cell RAM read, stage 2 registers palette lookup to RGB; hs, vs, visibility delayed identically, so RGB/hs/vs aligned, 2 pe after counter state.
REQ-026 Output black when not visible, outside grid and border, or EN=0.
REQ-027 Avalon write to cell/palette takes effect on display no later than 3 pe after the write; no tearing guarantee.
REQ-028 Cell RAM and palette dual-ported: Avalon side never stalls display side; same-address collision -> display may see old or new value.

Reset
REQ-029 RESET asserted (any time, including mid-frame or mid-read) SHALL immediately clear hc, vc, divider, pipeline, control register, AVL_READDATA to 0, drive RGB 0, hs=1, vs=1.
REQ-030 Palette SHALL reset to entry 0 = black, all others = full white; cell RAM contents undefined after power-up and unchanged by RESET.
REQ-031 After RESET release, first pe occurs CLK_DIV cycles later; frame starts at hc=0, vc=0.

Verification
REQ-032 Reset mid-line at hc=300 -> outputs black, hs=vs=1 same cycle; after release hs first falls at pixel 656 of line 0.
REQ-033 Free run one frame, defaults -> exactly 800*525*2 CLK between vs falling edges; hs low 96 pixels; vs low 2 lines.
REQ-034 Write palette[5]=0x0F80, cell 0=5, control=0x1 -> pixel (240,80)..(255,95) outputs r=0xF g=0x8 b=0x0; pixel (256,80) shows cell 1 code colour.
REQ-035 Write 0xABCD to cell 3 with BYTE_EN=4'b0010 -> cell unchanged, read returns old value one cycle after AVL_READ.
REQ-036 Read address beyond control -> AVL_READDATA=0; simultaneous read+write to palette[2] -> palette updated, AVL_READDATA holds prior value.
REQ-037 Control border code=7, EN=1 -> pixels (239,80) and (400,80) white; EN=0 -> whole frame black, syncs unchanged.

Source files
------------

// File: rtl/vga_grid_avl_interface.sv
// Avalon-MM tile-grid renderer for 640x480 VGA: cell RAM, palette and control register.
// Latency: RGB/hs/vs lag the pixel counters by 2 pixel enables; the Avalon side never stalls.
module vga_grid_avl_interface #(
  parameter int COLS    = 10,
  parameter int ROWS    = 20,
  parameter int CELL_PX = 16,
  parameter int CODE_W  = 3,
  parameter int COLOR_W = 4,
  parameter int X0      = 240,
  parameter int Y0      = 80,
  parameter int CLK_DIV = 2,
  localparam int A      = $clog2(COLS*ROWS + 2**CODE_W + 1)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               AVL_CS,
  input  logic               AVL_READ,
  input  logic               AVL_WRITE,
  input  logic [3:0]         AVL_BYTE_EN,
  input  logic [A-1:0]       AVL_ADDR,
  input  logic [31:0]        AVL_WRITEDATA,
  output logic [31:0]        AVL_READDATA,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               hs,
  output logic               vs
);

  localparam int N      = COLS*ROWS;
  localparam int PAL    = 2**CODE_W;
  localparam int CTRL   = N + PAL;
  localparam int RGB_W  = 3*COLOR_W;
  localparam int CIDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SH     = $clog2(CELL_PX);
  localparam logic [11:0] GX0 = 12'(X0);
  localparam logic [11:0] GX1 = 12'(X0 + COLS*CELL_PX);
  localparam logic [11:0] GY0 = 12'(Y0);
  localparam logic [11:0] GY1 = 12'(Y0 + ROWS*CELL_PX);

  logic [CODE_W-1:0] cell_mem [N];
  logic [RGB_W-1:0]  pal [PAL];
  logic              en;
  logic [CODE_W-1:0] border;

  // ---------------- Avalon slave ----------------
  logic [31:0]       a32;
  logic              is_cell, is_pal, is_ctrl, wr, rd;
  logic [CIDX_W-1:0] cell_a;
  logic [CODE_W-1:0] pal_a;
  logic [31:0]       old_word, new_word;

  assign a32 = 32'(AVL_ADDR);
  assign wr  = AVL_CS & AVL_WRITE;
  assign rd  = AVL_CS & AVL_READ & ~AVL_WRITE;

  // old_word doubles as read data and as the base for byte-lane merging
  always_comb begin
    is_cell  = (a32 < N);
    is_pal   = (a32 >= N) && (a32 < CTRL);
    is_ctrl  = (a32 == CTRL);
    cell_a   = is_cell ? CIDX_W'(a32) : '0;
    pal_a    = CODE_W'(a32 - N);
    old_word = '0;
    if (is_cell)      old_word = 32'(cell_mem[cell_a]);
    else if (is_pal)  old_word = 32'(pal[pal_a]);
    else if (is_ctrl) old_word = 32'({border, en});
    new_word = old_word;
    for (int k = 0; k < 4; k++)
      if (AVL_BYTE_EN[k]) new_word[8*k +: 8] = AVL_WRITEDATA[8*k +: 8];
  end

  // Cell RAM keeps its contents across RESET
  always_ff @(posedge CLK) begin
    if (wr && is_cell) cell_mem[cell_a] <= new_word[CODE_W-1:0];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < PAL; i++)
        pal[i] <= (i == 0) ? {RGB_W{1'b0}} : {RGB_W{1'b1}};
      en           <= 1'b0;
      border       <= '0;
      AVL_READDATA <= '0;
    end else begin
      if (wr && is_pal) pal[pal_a] <= new_word[RGB_W-1:0];
      if (wr && is_ctrl) begin
        en     <= new_word[0];
        border <= new_word[CODE_W:1];
      end
      if (rd) AVL_READDATA <= old_word;
    end
  end

  // ---------------- Display side ----------------
  logic [DIV_W-1:0]  div;
  logic              pe;
  logic [9:0]        hc, vc;
  logic [11:0]       hx, vy, rx, ry;
  logic              in_grid, in_frame, visible, hs_raw, vs_raw;
  logic [CIDX_W-1:0] cell_d;
  logic [CODE_W-1:0] s1_idx;
  logic              s1_draw, s1_hs, s1_vs;
  logic [RGB_W-1:0]  rgb;

  assign pe = (div == DIV_W'(CLK_DIV - 1));

  // Frame is the grid grown by one pixel on every side
  always_comb begin
    hx       = {2'b00, hc};
    vy       = {2'b00, vc};
    rx       = hx - GX0;
    ry       = vy - GY0;
    in_grid  = (hx >= GX0) && (hx < GX1) && (vy >= GY0) && (vy < GY1);
    in_frame = (hx + 12'd1 >= GX0) && (hx <= GX1) && (vy + 12'd1 >= GY0) && (vy <= GY1);
    cell_d   = in_grid ? CIDX_W'((ry >> SH) * COLS + (rx >> SH)) : '0;
    visible  = (hc < 10'd640) && (vc < 10'd480);
    hs_raw   = !((hc >= 10'd656) && (hc <= 10'd751));
    vs_raw   = !((vc >= 10'd490) && (vc <= 10'd491));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div     <= '0;
      hc      <= '0;
      vc      <= '0;
      s1_idx  <= '0;
      s1_draw <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
      rgb     <= '0;
      hs      <= 1'b1;
      vs      <= 1'b1;
    end else begin
      div <= pe ? '0 : div + DIV_W'(1);
      if (pe) begin
        if (hc == 10'd799) begin
          hc <= '0;
          vc <= (vc == 10'd524) ? 10'd0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
        s1_idx  <= in_grid ? cell_mem[cell_d] : border;
        s1_draw <= visible && in_frame;
        s1_hs   <= hs_raw;
        s1_vs   <= vs_raw;
        rgb     <= (s1_draw && en) ? pal[s1_idx] : '0;
        hs      <= s1_hs;
        vs      <= s1_vs;
      end
    end
  end

  assign red   = rgb[3*COLOR_W-1 -: COLOR_W];
  assign green = rgb[2*COLOR_W-1 -: COLOR_W];
  assign blue  = rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_grid_avl_interface.sv
// Scoreboard bench: a frame-level reference model predicts every pixel and Avalon read.
module tb_vga_grid_avl_interface;

  localparam int COLS = 10, ROWS = 6, CELL_PX = 4, CODE_W = 3, COLOR_W = 4;
  localparam int X0 = 240, Y0 = 3, CLK_DIV = 2;
  localparam int N = COLS*ROWS, PAL = 2**CODE_W, CTRL = N + PAL;
  localparam int A = $clog2(N + PAL + 1);
  localparam int GW = COLS*CELL_PX, GH = ROWS*CELL_PX;
  localparam int RGB_MASK = (1 << (3*COLOR_W)) - 1;

  logic               CLK = 1'b0, RESET = 1'b0;
  logic               AVL_CS = 1'b0, AVL_READ = 1'b0, AVL_WRITE = 1'b0;
  logic [3:0]         AVL_BYTE_EN = 4'h0;
  logic [A-1:0]       AVL_ADDR = '0;
  logic [31:0]        AVL_WRITEDATA = 32'h0;
  logic [31:0]        AVL_READDATA;
  logic [COLOR_W-1:0] red, green, blue;
  logic               hs, vs;

  always #5 CLK = ~CLK;

  vga_grid_avl_interface #(
    .COLS(COLS), .ROWS(ROWS), .CELL_PX(CELL_PX), .CODE_W(CODE_W),
    .COLOR_W(COLOR_W), .X0(X0), .Y0(Y0), .CLK_DIV(CLK_DIV)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .red(red), .green(green), .blue(blue), .hs(hs), .vs(vs)
  );

  int checks = 0, passed = 0;

  int m_cell [N];
  int m_pal [PAL];
  int m_en = 0, m_border = 0;
  int last_rd = 0;

  int unsigned kcnt = 0;
  bit tracking = 1'b0;
  bit rd_fire = 1'b0;
  int expq[$];
  int pq[$];
  int rdq[$];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void reset_model();
    m_pal[0] = 0;
    for (int i = 1; i < PAL; i++) m_pal[i] = RGB_MASK;
    m_en = 0;
    m_border = 0;
    last_rd = 0;
  endfunction

  function automatic int merge(int oldv, int data, logic [3:0] be);
    int r = oldv;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic void m_write(int a, int d, logic [3:0] be);
    int v;
    if (a < N) m_cell[a] = merge(m_cell[a], d, be) & (PAL-1);
    else if (a < CTRL) m_pal[a-N] = merge(m_pal[a-N], d, be) & RGB_MASK;
    else if (a == CTRL) begin
      v = merge(m_border*2 + m_en, d, be);
      m_en = v & 1;
      m_border = (v >> 1) & (PAL-1);
    end
  endfunction

  function automatic int m_read(int a);
    if (a < N) return m_cell[a];
    if (a < CTRL) return m_pal[a-N];
    if (a == CTRL) return m_border*2 + m_en;
    return 0;
  endfunction

  // Expected {rgb, hs, vs} for absolute pixel p counted from reset release
  function automatic int pix_exp(int p);
    int hcv, vcv, code, rgbv;
    bit vis, grid, frame, hsv, vsv;
    hcv   = p % 800;
    vcv   = (p / 800) % 525;
    vis   = (hcv < 640) && (vcv < 480);
    hsv   = !((hcv >= 656) && (hcv <= 751));
    vsv   = !((vcv >= 490) && (vcv <= 491));
    grid  = (hcv >= X0) && (hcv < X0+GW) && (vcv >= Y0) && (vcv < Y0+GH);
    frame = (hcv >= X0-1) && (hcv <= X0+GW) && (vcv >= Y0-1) && (vcv <= Y0+GH);
    code  = grid ? m_cell[((vcv-Y0)/CELL_PX)*COLS + (hcv-X0)/CELL_PX] : m_border;
    rgbv  = (vis && frame && m_en != 0) ? m_pal[code] : 0;
    return (rgbv << 2) | (int'(hsv) << 1) | int'(vsv);
  endfunction

  // Stimulus side of the scoreboard: predict the pixel being captured at each pixel enable
  always @(posedge CLK) begin
    rd_fire = AVL_CS && AVL_READ && !AVL_WRITE && !RESET;
    if (RESET) kcnt = 0;
    else if (tracking) begin
      kcnt++;
      if (kcnt % CLK_DIV == 0) begin
        expq.push_back(pix_exp(int'(kcnt/CLK_DIV) - 1));
        pq.push_back(int'(kcnt/CLK_DIV) - 1);
      end
    end
  end

  // Monitor: pixel outputs and read data
  always @(negedge CLK) begin
    int e, p, act;
    if (expq.size() >= 2) begin
      e   = expq.pop_front();
      p   = pq.pop_front();
      act = int'({red, green, blue, hs, vs});
      checks++;
      if (act == e) passed++;
      else $display("FAIL pixel(%0d,%0d): got {rgb,hs,vs}=0x%0h, expected 0x%0h",
                    p % 800, (p / 800) % 525, act, e);
    end
    if (rd_fire) begin
      if (rdq.size() == 0) begin
        checks++;
        $display("FAIL avl_readdata: read data 0x%0h with no read outstanding", AVL_READDATA);
      end else check("avl_readdata", int'(AVL_READDATA), rdq.pop_front());
    end
  end

  task automatic avl(bit r, bit w, int a, int d, logic [3:0] be);
    @(posedge CLK); #1;
    AVL_CS = 1'b1; AVL_READ = r; AVL_WRITE = w;
    AVL_ADDR = A'(a); AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    if (r && !w) begin
      last_rd = m_read(a);
      rdq.push_back(last_rd);
    end
    if (w) m_write(a, d, be);
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic wait_until(int target);
    int i = 0;
    while (int'(kcnt/CLK_DIV) < target && i < 60000) begin
      @(posedge CLK); #1;
      i++;
    end
    checks++;
    if (int'(kcnt/CLK_DIV) >= target) passed++;
    else $display("FAIL wait_timeout: reached pixel %0d, required %0d", kcnt/CLK_DIV, target);
  endtask

  task automatic fill_palette();
    for (int j = 1; j < PAL; j++) begin
      if (j == 5) avl(0, 1, N+j, 32'h0F80, 4'hF);
      else if (j == 7) avl(0, 1, N+j, 32'h0FFF, 4'hF);
      else avl(0, 1, N+j, int'($urandom_range(0, RGB_MASK)), 4'hF);
    end
  endtask

  // Cell 14 and palette 5 stay fixed so the mid-line reset lands on a lit pixel
  task automatic rand_op();
    int a = int'($urandom_range(0, (1 << A) - 1));
    if (a == 14 || a == N+5 || a == CTRL) a = 1;
    if ($urandom_range(0, 3) == 0) avl(1, 0, a, 0, 4'h0);
    else avl(0, 1, a, int'($urandom), 4'($urandom_range(0, 15)));
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_cell[i] = 0;
    reset_model();

    #2 RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_red", int'(red), 0);
    check("reset_green", int'(green), 0);
    check("reset_blue", int'(blue), 0);
    check("reset_hs", int'(hs), 1);
    check("reset_vs", int'(vs), 1);
    check("reset_readdata", int'(AVL_READDATA), 0);
    @(negedge CLK);
    RESET = 1'b0;
    tracking = 1'b1;

    // Register-level behaviour while the display is disabled
    avl(0, 1, 3, 5, 4'hF);
    avl(1, 0, 3, 0, 4'h0);
    avl(0, 1, 3, 32'hABCD, 4'b0010);
    avl(1, 0, 3, 0, 4'h0);
    avl(1, 0, CTRL+1, 0, 4'h0);
    avl(1, 0, (1 << A) - 1, 0, 4'h0);
    avl(1, 0, N+1, 0, 4'h0);
    avl(1, 0, CTRL, 0, 4'h0);
    avl(1, 0, N, 0, 4'h0);
    avl(1, 1, N+2, 32'h123, 4'hF);
    check("rw_readdata_hold", int'(AVL_READDATA), last_rd);
    avl(1, 0, N+2, 0, 4'h0);
    avl(0, 1, N+4, 32'h0A5, 4'b0001);
    avl(1, 0, N+4, 0, 4'h0);
    avl(0, 1, CTRL, 32'hFF, 4'h0);
    avl(1, 0, CTRL, 0, 4'h0);

    for (int i = 0; i < N; i++) avl(0, 1, i, int'($urandom), 4'hF);
    avl(0, 1, 0, 5, 4'hF);
    avl(0, 1, 14, 5, 4'hF);
    fill_palette();

    wait_until(660);
    avl(0, 1, CTRL, 32'hF, 4'hF);
    for (int l = 1; l <= 9; l++) begin
      wait_until(l*800 + 660);
      if (l == 5) avl(0, 1, CTRL, 32'hE, 4'hF);
      else if (l == 7) avl(0, 1, CTRL, 32'hF, 4'hF);
      else if (l == 9) avl(1, 0, N+5, 0, 4'h0);
      else repeat (3) rand_op();
    end

    // Reset in the middle of a lit grid line
    wait_until(10*800 + 260);
    RESET = 1'b1;
    tracking = 1'b0;
    expq.delete();
    pq.delete();
    reset_model();
    #1;
    check("midline_rgb", int'({red, green, blue}), 0);
    check("midline_hs", int'(hs), 1);
    check("midline_vs", int'(vs), 1);
    check("midline_readdata", int'(AVL_READDATA), 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    tracking = 1'b1;

    for (int j = 0; j < PAL; j++) avl(1, 0, N+j, 0, 4'h0);
    avl(1, 0, 14, 0, 4'h0);
    avl(1, 0, CTRL, 0, 4'h0);
    fill_palette();
    wait_until(660);
    avl(0, 1, CTRL, 32'hF, 4'hF);
    for (int l = 1; l <= 28; l++) begin
      wait_until(l*800 + 660);
      repeat (2) rand_op();
    end
    wait_until(29*800);
    repeat (10) @(posedge CLK);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
